// File: rtl/jpeg_cone_chain_pipe.sv
// Pipelined generate/propagate carry-cone (mode 0) / unsigned A>=B compare cone (mode 1).
// Optional handshake counter output stat_cnt is enabled by defining JPEG_CONE_STATS_EN.
module jpeg_cone_chain_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_cone,
    output logic             out_cone_n,
    output logic             out_allprop
`ifdef JPEG_CONE_STATS_EN
    ,
    output logic [15:0]      stat_cnt
`endif
);

    localparam int SL = WIDTH / STAGES;

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] cry_p;
    logic [STAGES-1:0] allp_p;
    logic [STAGES-1:0] mode_p;
    logic [WIDTH-1:0]  a_p [STAGES];
    logic [WIDTH-1:0]  b_p [STAGES];
    logic [1:0]        res [STAGES];
    logic              accept;

    // Ripple one slice of the chain; returns {carry_out, slice_allprop}.
    function automatic logic [1:0] resolve(input logic [SL-1:0] a, input logic [SL-1:0] b,
                                           input logic mode, input logic cin);
        logic c;
        logic ap;
        logic bi;
        c  = cin;
        ap = 1'b1;
        for (int i = 0; i < SL; i++) begin
            bi = mode ? ~b[i] : b[i];
            c  = (a[i] & bi) | ((a[i] | bi) & c);
            ap = ap & (a[i] | bi);
        end
        return {c, ap};
    endfunction

    // A stage may load whenever any stage at or after it has a free slot, or the sink drains.
    for (genvar k = 0; k < STAGES; k++) begin : g_adv
        assign adv[k] = out_ready | ~(&vld_p[STAGES-1:k]);
    end

    assign in_ready = ~rst & adv[0];
    assign accept   = in_valid & in_ready;

    // Compare mode seeds the chain with 1 so that A + ~B + 1 carries out iff A >= B.
    assign res[0] = resolve(in_a[SL-1:0], in_b[SL-1:0], in_mode, in_mode | in_cin);
    for (genvar k = 1; k < STAGES; k++) begin : g_res
        assign res[k] = resolve(a_p[k-1][k*SL +: SL], b_p[k-1][k*SL +: SL],
                                mode_p[k-1], cry_p[k-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            if (adv[0]) vld_p[0] <= accept;
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) vld_p[k] <= vld_p[k-1];
            end
        end
    end

    // ---- stage 0 captures the first slice; stage k folds in slice k ----
    always_ff @(posedge clk) begin
        if (accept) begin
            cry_p[0]  <= res[0][1];
            allp_p[0] <= res[0][0];
            mode_p[0] <= in_mode;
            a_p[0]    <= in_a;
            b_p[0]    <= in_b;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k] && vld_p[k-1]) begin
                cry_p[k]  <= res[k][1];
                allp_p[k] <= allp_p[k-1] & res[k][0];
                mode_p[k] <= mode_p[k-1];
                a_p[k]    <= a_p[k-1];
                b_p[k]    <= b_p[k-1];
            end
        end
    end

    // ---- output: data registers are unreset, so results are masked by valid ----
    assign out_valid   = vld_p[STAGES-1] & ~rst;
    assign out_cone    = out_valid & cry_p[STAGES-1];
    assign out_cone_n  = ~out_cone;
    assign out_allprop = out_valid & allp_p[STAGES-1];

`ifdef JPEG_CONE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt <= '0;
        end else if (out_valid && out_ready && stat_cnt != 16'hFFFF) begin
            stat_cnt <= stat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jpeg_cone_chain_pipe.sv
// Scoreboard bench for jpeg_cone_chain_pipe: an 8-bit/2-stage instance for directed
// scenarios and a 16-bit/4-stage instance for the randomised stream.
module tb_jpeg_cone_chain_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic        in_valid1 = 0, in_cin1 = 0, in_mode1 = 0, out_ready1 = 1;
    logic [7:0]  in_a1 = '0, in_b1 = '0;
    logic        in_ready1, out_valid1, out_cone1, out_cone_n1, out_allprop1;

    logic        in_valid2 = 0, in_cin2 = 0, in_mode2 = 0, out_ready2 = 1;
    logic [15:0] in_a2 = '0, in_b2 = '0;
    logic        in_ready2, out_valid2, out_cone2, out_cone_n2, out_allprop2;
`ifdef JPEG_CONE_STATS_EN
    logic [15:0] stat_cnt1, stat_cnt2;
`endif

    jpeg_cone_chain_pipe #(.WIDTH(8), .STAGES(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1), .in_mode(in_mode1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_cone(out_cone1),
        .out_cone_n(out_cone_n1), .out_allprop(out_allprop1)
`ifdef JPEG_CONE_STATS_EN
        , .stat_cnt(stat_cnt1)
`endif
    );

    jpeg_cone_chain_pipe #(.WIDTH(16), .STAGES(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a2), .in_b(in_b2), .in_cin(in_cin2), .in_mode(in_mode2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_cone(out_cone2),
        .out_cone_n(out_cone_n2), .out_allprop(out_allprop2)
`ifdef JPEG_CONE_STATS_EN
        , .stat_cnt(stat_cnt2)
`endif
    );

    int total = 0;
    int bad   = 0;
    logic [2:0] q1[$];
    logic [2:0] q2[$];
    int hs1 = 0;

    // Reference: arithmetic carry-out of A+B+cin, or unsigned A>=B; returns {cone, ~cone, allprop}.
    function automatic logic [2:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic c, input logic m, input int w);
        logic [63:0] mask;
        logic [64:0] s;
        logic cone, ap;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        if (m) begin
            cone = (a & mask) >= (b & mask);
            ap   = &((a | ~b) | ~mask);
        end else begin
            s    = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, c};
            cone = s[w];
            ap   = &((a | b) | ~mask);
        end
        return {cone, ~cone, ap};
    endfunction

    task automatic cyc1(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic m, input logic ordy,
                        output logic ir, output logic full_b, output logic got,
                        output logic [2:0] act, output logic [2:0] exp);
        @(negedge clk);
        in_valid1 = v; in_a1 = a; in_b1 = b; in_cin1 = c; in_mode1 = m; out_ready1 = ordy;
        #1;
        ir = in_ready1;
        full_b = (q1.size() == 2);
        got = 0; act = '0; exp = '0;
        if (out_valid1 && out_ready1) begin
            got = 1;
            hs1++;
            act = {out_cone1, out_cone_n1, out_allprop1};
            exp = (q1.size() > 0) ? q1.pop_front() : 3'b111;
        end
        if (v && in_ready1) q1.push_back(model({56'd0, a}, {56'd0, b}, c, m, 8));
    endtask

    task automatic cyc2(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic m, input logic ordy,
                        output logic ir, output logic got,
                        output logic [2:0] act, output logic [2:0] exp);
        @(negedge clk);
        in_valid2 = v; in_a2 = a; in_b2 = b; in_cin2 = c; in_mode2 = m; out_ready2 = ordy;
        #1;
        ir = in_ready2;
        got = 0; act = '0; exp = '0;
        if (out_valid2 && out_ready2) begin
            got = 1;
            act = {out_cone2, out_cone_n2, out_allprop2};
            exp = (q2.size() > 0) ? q2.pop_front() : 3'b111;
        end
        if (v && in_ready2) q2.push_back(model({48'd0, a}, {48'd0, b}, c, m, 16));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({out_valid1, in_ready1, out_cone1, out_cone_n1, out_allprop1} !== 5'b00010) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 00010",
                     {out_valid1, in_ready1, out_cone1, out_cone_n1, out_allprop1});
        end
        total++;
        if ({out_valid2, in_ready2, out_cone_n2} !== 3'b001) begin
            bad++;
            $display("FAIL reset_outputs_w16: got %b want 001", {out_valid2, in_ready2, out_cone_n2});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready1 !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got %b want 1", in_ready1);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        in_valid1 = 1; in_a1 = 8'hFF; in_b1 = 8'h01; in_cin1 = 0; in_mode1 = 0; out_ready1 = 1;
        #1;
        total++;
        if (in_ready1 !== 1'b1) begin
            bad++; $display("FAIL basic_in_ready: got %b want 1", in_ready1);
        end
        @(negedge clk);
        in_valid1 = 0;
        #1;
        total++;
        if (out_valid1 !== 1'b0) begin
            bad++; $display("FAIL basic_latency_early: got %b want 0", out_valid1);
        end
        @(negedge clk);
        #1;
        total++;
        if ({out_valid1, out_cone1, out_cone_n1, out_allprop1} !== 4'b1101) begin
            bad++;
            $display("FAIL basic_result: got %b want 1101",
                     {out_valid1, out_cone1, out_cone_n1, out_allprop1});
        end
        @(negedge clk);
        #1;
        total++;
        if (out_valid1 !== 1'b0) begin
            bad++; $display("FAIL basic_drained: got %b want 0", out_valid1);
        end
    endtask

    task automatic test_compare();
        logic ir, fb, got;
        logic [2:0] act, exp;
        int outs;
        logic want [2];
        want[0] = 1'b1;
        want[1] = 1'b0;
        outs = 0;
        cyc1(1, 8'h05, 8'h05, 0, 1, 1, ir, fb, got, act, exp);
        cyc1(1, 8'h04, 8'h05, 1, 1, 1, ir, fb, got, act, exp);
        for (int i = 0; i < 10 && outs < 2; i++) begin
            cyc1(0, 8'h00, 8'h00, 0, 0, 1, ir, fb, got, act, exp);
            if (got) begin
                total++;
                if (act !== exp || act[2] !== want[outs]) begin
                    bad++;
                    $display("FAIL compare_beat%0d: got %b want %b (cone %b)", outs, act, exp, want[outs]);
                end
                outs++;
            end
        end
        total++;
        if (outs != 2) begin
            bad++; $display("FAIL compare_count: got %0d want 2", outs);
        end
    endtask

    task automatic test_stall();
        logic ir, fb, got, ordy, hold;
        logic [2:0] act, exp;
        logic [3:0] held;
        int sent, outs, stall_left;
        sent = 0; outs = 0; stall_left = 3; hold = 0; held = '0;
        for (int cyc = 0; cyc < 200 && outs < 10; cyc++) begin
            ordy = 1'b1;
            if (outs == 3 && stall_left > 0) begin
                ordy = 1'b0;
                stall_left--;
            end
            cyc1(sent < 10, 8'(sent * 37 + 3), 8'(sent * 11 + 200), sent[1], sent[0], ordy,
                 ir, fb, got, act, exp);
            total++;
            if (ir !== !(fb && !ordy)) begin
                bad++; $display("FAIL stall_in_ready: got %b want %b", ir, !(fb && !ordy));
            end
            if (hold) begin
                total++;
                if ({out_valid1, out_cone1, out_cone_n1, out_allprop1} !== held) begin
                    bad++;
                    $display("FAIL stall_hold: got %b want %b",
                             {out_valid1, out_cone1, out_cone_n1, out_allprop1}, held);
                end
            end
            hold = out_valid1 & !ordy;
            held = {out_valid1, out_cone1, out_cone_n1, out_allprop1};
            if (sent < 10 && ir) sent++;
            if (got) begin
                total++;
                if (act !== exp) begin
                    bad++; $display("FAIL stall_result%0d: got %b want %b", outs, act, exp);
                end
                outs++;
            end
        end
        total++;
        if (outs != 10 || sent != 10 || q1.size() != 0) begin
            bad++; $display("FAIL stall_count: got out=%0d in=%0d want 10/10", outs, sent);
        end
    endtask

    task automatic test_reset_midstream();
        logic ir, fb, got;
        logic [2:0] act, exp;
        cyc1(1, 8'hAA, 8'h55, 1, 0, 0, ir, fb, got, act, exp);
        cyc1(1, 8'h10, 8'h20, 0, 1, 0, ir, fb, got, act, exp);
        @(negedge clk);
        in_valid1 = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q1.delete();
        #1;
        total++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            bad++;
            $display("FAIL midreset_ready: got ready=%b valid=%b want 1/0", in_ready1, out_valid1);
        end
`ifdef JPEG_CONE_STATS_EN
        total++;
        if (stat_cnt1 !== 16'd0) begin
            bad++; $display("FAIL midreset_stat: got %0d want 0", stat_cnt1);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            cyc1(0, 8'h00, 8'h00, 0, 0, 1, ir, fb, got, act, exp);
            total++;
            if (got) begin
                bad++; $display("FAIL midreset_ghost: got beat %b want none", act);
            end
        end
    endtask

    task automatic test_random();
        logic ir, got, v;
        logic [2:0] act, exp;
        logic [15:0] a, b;
        logic c, m;
        int sent, outs;
        sent = 0; outs = 0;
        a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); m = 1'($urandom);
        for (int cyc = 0; cyc < 40000 && (sent < 10000 || q2.size() != 0); cyc++) begin
            v = (sent < 10000) && ($urandom_range(0, 9) < 8);
            if (($urandom_range(0, 15) == 0) && sent < 10000) begin
                a = 16'hFFFF; b = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h0000;
            end
            cyc2(v, a, b, c, m, $urandom_range(0, 3) != 0, ir, got, act, exp);
            if (v && ir) begin
                sent++;
                a = 16'($urandom); b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
                c = 1'($urandom); m = 1'($urandom);
            end
            if (got) begin
                total++;
                if (act !== exp) begin
                    bad++; $display("FAIL random_beat%0d: got %b want %b", outs, act, exp);
                end
                outs++;
            end
        end
        total++;
        if (outs != 10000 || sent != 10000) begin
            bad++; $display("FAIL random_count: got out=%0d in=%0d want 10000", outs, sent);
        end
    endtask

`ifdef JPEG_CONE_STATS_EN
    task automatic test_stats();
        logic ir, fb, got;
        logic [2:0] act, exp;
        int before;
        hs1 = 0;
        q1.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 70000 && hs1 < 65540; cyc++) begin
            before = hs1;
            cyc1(1, 8'(cyc), 8'(cyc >> 3), cyc[4], cyc[5], 1, ir, fb, got, act, exp);
            if (before == 1000) begin
                total++;
                if (stat_cnt1 !== 16'd1000) begin
                    bad++; $display("FAIL stat_mid: got %0d want 1000", stat_cnt1);
                end
            end
            if (got && act !== exp) begin
                total++;
                bad++; $display("FAIL stat_stream: got %b want %b", act, exp);
            end
        end
        cyc1(0, 8'h00, 8'h00, 0, 0, 0, ir, fb, got, act, exp);
        total++;
        if (hs1 < 65540 || stat_cnt1 !== 16'hFFFF) begin
            bad++; $display("FAIL stat_saturate: got %0d after %0d want 65535", stat_cnt1, hs1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_compare();
        test_stall();
        test_reset_midstream();
        test_random();
`ifdef JPEG_CONE_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jpeg_cone_chain_pipe.md
JPEG_CONE_CHAIN_PIPE -- requirements
Module: jpeg_cone_chain_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width, equal to chain length; legal range 2..64.
REQ-002 SHALL have parameter STAGES, default 2: number of register stages; WIDTH % STAGES == 0, 1 <= STAGES <= WIDTH.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: input beat present.
REQ-006 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-007 SHALL have port in_a, input, WIDTH: operand A.
REQ-008 SHALL have port in_b, input, WIDTH: operand B.
REQ-009 SHALL have port in_cin, input, 1: chain seed; used only in mode 0.
REQ-010 SHALL have port in_mode, input, 1: 0 = carry cone, 1 = compare cone (A >= B).
REQ-011 SHALL have port out_valid, output, 1: result beat present.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port out_cone, output, 1: chain result.
REQ-014 SHALL have port out_cone_n, output, 1: inverted result, always ~out_cone.
REQ-015 SHALL have port out_allprop, output, 1: AND of all propagate bits.

Function
REQ-016 Per bit i, SHALL compute bi = in_b[i] when mode 0, and bi = ~in_b[i] when mode 1.
REQ-017 SHALL compute g_i = in_a[i] & bi and p_i = in_a[i] | bi.
REQ-018 SHALL compute the chain c_{i+1} = g_i | (p_i & c_i), with c_0 = in_cin in mode 0 and c_0 = 1 in mode 1.
REQ-019 out_cone SHALL equal c_WIDTH; out_allprop SHALL equal the AND of all p_i.
REQ-020 Stage k SHALL resolve bits [k*WIDTH/STAGES, (k+1)*WIDTH/STAGES-1] and register them.
REQ-021 Each stage register SHALL hold: partial carry, partial allprop, the unresolved operand slices, mode, and a valid bit.
REQ-022 Stage k SHALL advance when !valid_{k+1} or when stage k+1 advances; the last stage SHALL advance when out_ready is high.
REQ-023 in_ready SHALL equal (!valid_0 | stage 0 advances); a beat transfers on in_valid & in_ready.
REQ-024 Latency with out_ready held high SHALL be exactly STAGES cycles from accept to out_valid; throughput SHALL be 1 beat/cycle.
REQ-025 While out_valid & !out_ready, out_cone, out_cone_n and out_allprop SHALL hold stable and no beat SHALL be lost or duplicated.
REQ-026 On a simultaneous accept and drain with a full pipe, the pipe SHALL shift; results SHALL be in-order and equal in count to beats accepted.
REQ-027 in_a, in_b, in_cin and in_mode SHALL be ignored when in_valid is 0.
REQ-028 mode SHALL be captured per beat; mixed-mode streams SHALL be legal.

Reset
REQ-029 While rst is high, all valid bits SHALL clear to 0 and out_valid SHALL be 0.
REQ-030 While rst is high, in_ready SHALL be 0.
REQ-031 While rst is high, out_cone SHALL be 0, out_cone_n SHALL be 1 and out_allprop SHALL be 0.
REQ-032 Reset asserted mid-stream SHALL discard all in-flight beats; in_ready SHALL be 1 on the first cycle after rst falls.

Configuration
REQ-033 With JPEG_CONE_STATS_EN defined, SHALL add output stat_cnt (16 bits), counting out_valid & out_ready handshakes, saturating at 16'hFFFF and cleared by rst.
REQ-034 Without JPEG_CONE_STATS_EN, stat_cnt SHALL not exist and no counter logic SHALL be present.

Verification
REQ-035 WIDTH=8, STAGES=2, mode 0, A=8'hFF, B=8'h01, cin=0 -> after 2 cycles out_cone=1, out_cone_n=0, out_allprop=1.
REQ-036 Mode 1 compare -> A=8'h05, B=8'h05 gives out_cone=1; A=8'h04, B=8'h05 gives out_cone=0.
REQ-037 Stream of 10 beats with out_ready low for 3 cycles at beat 4 -> all 10 results in order, outputs stable during the stall, in_ready low only while the pipe is full.
REQ-038 rst pulsed for 1 cycle with 2 beats in flight -> neither beat emerges; in_ready=1 the next cycle; stat_cnt=0 when JPEG_CONE_STATS_EN is defined.
REQ-039 JPEG_CONE_STATS_EN defined, 65540 handshakes -> stat_cnt=16'hFFFF.
REQ-040 Random 10k beats, WIDTH=16, STAGES=4, with random stalls -> every result matches the reference model of REQ-016 to REQ-019.
